// File: rtl/even_updown_sequencer.sv
// -----------------------------------------------------------------------------
// even_updown_sequencer
//
// Controller for a 4-bit even up/down counter (T-flip-flop based, steps by 2,
// y selects direction: 0 = up, 1 = down). It runs the counter through a
// programmed number of ping-pong laps lo -> hi -> lo between two even bounds.
// It drives the counter's direction, step enable and clear inputs and watches
// the counter state q.
//
// Optional feature macro: SEQ_WATCHDOG_EN
//   When defined, a shadow copy of the expected counter value is kept. Any
//   cycle in SEEK/UP/DOWN where q differs from it raises an err pulse and
//   returns the controller to IDLE. When undefined, err only flags a rejected
//   start (lo >= hi).
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   synchronous, active-low reset
//   start     in   host run request (level, sampled in IDLE only)
//   stop      in   host abort, sampled every cycle, highest priority
//   lo_bound  in   lower turn-around value (bit0 forced to 0)
//   hi_bound  in   upper turn-around value (bit0 forced to 0)
//   laps      in   number of lo->hi->lo laps, 0 = run until stop
//   q         in   current counter state
//   y         out  counter direction, 0 = up, 1 = down
//   step      out  counter advance enable (combinational on q)
//   cnt_clr   out  synchronous counter clear request
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse on run completion
//   lap_cnt   out  completed laps in the current or last run
//   err       out  one-cycle pulse on rejected start or watchdog trip
// -----------------------------------------------------------------------------
module even_updown_sequencer #(
  parameter int WIDTH  = 4,
  parameter int LAPS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  input  logic [LAPS_W-1:0] laps,
  input  logic [WIDTH-1:0]  q,
  output logic              y,
  output logic              step,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
  output logic [LAPS_W-1:0] lap_cnt,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SEEK  = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] EVEN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [LAPS_W-1:0]   laps_q, laps_d;
  logic [LAPS_W-1:0]   lap_cnt_q, lap_cnt_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    lo_new;
  logic [WIDTH-1:0]    hi_new;
  logic [LAPS_W-1:0]   lap_inc;

`ifdef SEQ_WATCHDOG_EN
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic                wd_trip;
`endif

  always_comb begin
    // Bounds are forced even; masking keeps every input bit referenced.
    lo_new    = lo_bound & EVEN_MASK;
    hi_new    = hi_bound & EVEN_MASK;
    lap_inc   = lap_cnt_q + LAPS_W'(1);

    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    laps_d    = laps_q;
    lap_cnt_d = lap_cnt_q;
    err_d     = 1'b0;

    y         = 1'b0;
    step      = 1'b0;
    cnt_clr   = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          lo_d      = lo_new;
          hi_d      = hi_new;
          laps_d    = laps;
          lap_cnt_d = '0;
          if (lo_new >= hi_new) err_d   = 1'b1;
          else                  state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        state_d = SEEK;
      end
      SEEK: begin
        if (q != lo_q) step    = 1'b1;
        else           state_d = UP;
      end
      UP: begin
        if (q != hi_q) step    = 1'b1;
        else           state_d = DOWN;
      end
      DOWN: begin
        y = 1'b1;
        if (q != lo_q) begin
          step = 1'b1;
        end else begin
          lap_cnt_d = lap_inc;
          if ((laps_q != '0) && (lap_inc == laps_q)) state_d = DONE;
          else                                      state_d = UP;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SEQ_WATCHDOG_EN
    // A counter that disagrees with the shadow value is stuck or misdirected.
    wd_trip = ((state_q == SEEK) || (state_q == UP) || (state_q == DOWN)) &&
              (q != exp_q);
    if (wd_trip) begin
      state_d   = IDLE;
      step      = 1'b0;
      lap_cnt_d = lap_cnt_q;
      err_d     = 1'b1;
    end
`endif

    // Abort wins over every other transition, including a pending done.
    if (stop && (state_q != IDLE)) begin
      state_d   = IDLE;
      step      = 1'b0;
      done      = 1'b0;
      lap_cnt_d = lap_cnt_q;
      err_d     = 1'b0;
    end

`ifdef SEQ_WATCHDOG_EN
    // Shadow tracks the step actually issued, after all gating.
    exp_d = exp_q;
    if (state_q == CLEAR) exp_d = '0;
    else if (step)        exp_d = y ? (exp_q - WIDTH'(2)) : (exp_q + WIDTH'(2));
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      laps_q    <= '0;
      lap_cnt_q <= '0;
      err_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      exp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      laps_q    <= laps_d;
      lap_cnt_q <= lap_cnt_d;
      err_q     <= err_d;
`ifdef SEQ_WATCHDOG_EN
      exp_q     <= exp_d;
`endif
    end
  end

  assign lap_cnt = lap_cnt_q;
  assign err     = err_q;

endmodule
